// File: rtl/lp_filter_pkg.sv
// Shared types for the multichannel signed low-pass filter: bounds, channel-index width
// helper and the record that travels down the stage pipeline with each sample.
package lp_filter_pkg;

    localparam int MAX_STAGES     = 8;
    localparam int MAX_CHAN_BITS  = 8;
    localparam int MAX_SHIFT_BITS = 8;
    localparam int MAX_VALUE_BITS = 64;

    // Fields are sized for the largest configuration; modules use the low bits they need.
    typedef struct packed {
        logic                      valid;
        logic                      load;
        logic [MAX_CHAN_BITS-1:0]  channel;
        logic [MAX_SHIFT_BITS-1:0] shift;
        logic [MAX_VALUE_BITS-1:0] value;
    } stage_t;

    function automatic int chan_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lp_filter_mc_stage.sv
// One first-order smoothing stage with a per-channel accumulator array; one register
// of latency. A load sample overwrites the channel accumulator with the stage input.
module lp_filter_mc_stage
    import lp_filter_pkg::*;
#(
    parameter int OUT_DATA_BITS = 33,
    parameter int SHIFT_BITS    = 5,
    parameter int CHANNEL_COUNT = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   ce,
    input  logic   clear,
    input  stage_t in_s,
    output stage_t out_s
);

    localparam int CW = chan_bits(CHANNEL_COUNT);
    localparam int DW = OUT_DATA_BITS + 1;

    logic signed [OUT_DATA_BITS-1:0] acc_q [CHANNEL_COUNT];
    logic signed [OUT_DATA_BITS-1:0] acc_d [CHANNEL_COUNT];
    stage_t                          out_q;
    stage_t                          out_d;

    logic [CW-1:0]                   ch;
    logic signed [OUT_DATA_BITS-1:0] x;
    logic signed [OUT_DATA_BITS-1:0] acc_cur;
    logic signed [OUT_DATA_BITS-1:0] acc_new;
    logic signed [DW-1:0]            diff;
    logic signed [DW-1:0]            step;
    logic [DW-1:0]                   sum;
    logic                            unused_bits;

    // The difference is one bit wider so x - acc never overflows before the floor shift.
    always_comb begin
        ch      = in_s.channel[CW-1:0];
        x       = in_s.value[OUT_DATA_BITS-1:0];
        acc_cur = acc_q[ch];
        diff    = {x[OUT_DATA_BITS-1], x} - {acc_cur[OUT_DATA_BITS-1], acc_cur};
        step    = diff >>> in_s.shift[SHIFT_BITS-1:0];
        sum     = {acc_cur[OUT_DATA_BITS-1], acc_cur} + step;
        acc_new = in_s.load ? x : sum[OUT_DATA_BITS-1:0];
    end

    always_comb begin
        acc_d = acc_q;
        out_d = out_q;
        if (ce) begin
            if (clear) begin
                for (int i = 0; i < CHANNEL_COUNT; i++) begin
                    acc_d[i] = '0;
                end
                out_d.valid = 1'b0;
            end else begin
                out_d       = in_s;
                out_d.value = MAX_VALUE_BITS'(acc_new);
                if (in_s.valid) begin
                    acc_d[ch] = acc_new;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '{default: '0};
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign out_s       = out_q;
    assign unused_bits = ^{in_s, sum[DW-1]};

endmodule

// File: rtl/lp_filter_signed_mc.sv
// Time-multiplexed multichannel cascade of first-order low-pass stages.
// Define LP_FILTER_SIGNED_MC_PRELOAD_EN to seed each channel from its first sample.
module lp_filter_signed_mc
    import lp_filter_pkg::*;
#(
    parameter int IN_DATA_BITS  = 30,
    parameter int OUT_DATA_BITS = 33,
    parameter int SHIFT_BITS    = 5,
    parameter int STAGE_COUNT   = 2,
    parameter int CHANNEL_COUNT = 4
) (
    input  logic                                CLK,
    input  logic                                RESET_N,
    input  logic                                CE,
    input  logic                                CLEAR,
    input  logic                                IN_VALID,
    input  logic [chan_bits(CHANNEL_COUNT)-1:0] IN_CHANNEL,
    input  logic signed [IN_DATA_BITS-1:0]      IN_VALUE,
    input  logic [SHIFT_BITS-1:0]               SHIFT,
    output logic                                OUT_VALID,
    output logic [chan_bits(CHANNEL_COUNT)-1:0] OUT_CHANNEL,
    output logic signed [OUT_DATA_BITS-1:0]     OUT_VALUE
);

    localparam int CW = chan_bits(CHANNEL_COUNT);
    localparam int NS = (STAGE_COUNT > MAX_STAGES) ? MAX_STAGES : STAGE_COUNT;

    // IN_VALID qualifies one sample per CE-high cycle with no backpressure; OUT_VALID is a
    // one-cycle pulse, and OUT_CHANNEL/OUT_VALUE keep the last emitted sample otherwise.
    stage_t                          pipe [NS+1];
    stage_t                          head;
    stage_t                          last;
    logic                            in_range;
    logic                            accept;
    logic                            load;
    logic signed [OUT_DATA_BITS-1:0] x_s;
    logic                            unused_last;

    if (CHANNEL_COUNT == (1 << CW)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = (IN_CHANNEL < CW'(CHANNEL_COUNT));
    end

    assign accept = IN_VALID && in_range && !CLEAR;
    assign x_s    = OUT_DATA_BITS'(IN_VALUE) <<< (OUT_DATA_BITS - IN_DATA_BITS);

`ifdef LP_FILTER_SIGNED_MC_PRELOAD_EN
    logic [CHANNEL_COUNT-1:0] primed_q;
    logic [CHANNEL_COUNT-1:0] primed_d;

    always_comb begin
        primed_d = primed_q;
        load     = 1'b0;
        if (in_range) begin
            load = !primed_q[IN_CHANNEL];
        end
        if (CE) begin
            if (CLEAR) begin
                primed_d = '0;
            end else if (accept) begin
                primed_d[IN_CHANNEL] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            primed_q <= '0;
        end else begin
            primed_q <= primed_d;
        end
    end
`else
    assign load = 1'b0;
`endif

    always_comb begin
        head         = '0;
        head.valid   = accept;
        head.load    = load;
        head.channel = MAX_CHAN_BITS'(IN_CHANNEL);
        head.shift   = MAX_SHIFT_BITS'(SHIFT);
        head.value   = MAX_VALUE_BITS'(x_s);
    end

    assign pipe[0] = head;

    for (genvar k = 0; k < NS; k++) begin : g_stage
        lp_filter_mc_stage #(
            .OUT_DATA_BITS (OUT_DATA_BITS),
            .SHIFT_BITS    (SHIFT_BITS),
            .CHANNEL_COUNT (CHANNEL_COUNT)
        ) u_stage (
            .clk   (CLK),
            .rst_n (RESET_N),
            .ce    (CE),
            .clear (CLEAR),
            .in_s  (pipe[k]),
            .out_s (pipe[k+1])
        );
    end

    assign last        = pipe[NS];
    assign unused_last = ^last;

    logic                            out_valid_q;
    logic                            out_valid_d;
    logic [CW-1:0]                   out_channel_q;
    logic [CW-1:0]                   out_channel_d;
    logic signed [OUT_DATA_BITS-1:0] out_value_q;
    logic signed [OUT_DATA_BITS-1:0] out_value_d;

    always_comb begin
        out_valid_d   = 1'b0;
        out_channel_d = out_channel_q;
        out_value_d   = out_value_q;
        if (CE && !CLEAR && last.valid) begin
            out_valid_d   = 1'b1;
            out_channel_d = last.channel[CW-1:0];
            out_value_d   = last.value[OUT_DATA_BITS-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_value_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_channel_q <= out_channel_d;
            out_value_q   <= out_value_d;
        end
    end

    assign OUT_VALID   = out_valid_q;
    assign OUT_CHANNEL = out_channel_q;
    assign OUT_VALUE   = out_value_q;

endmodule

// File: tb/tb_lp_filter_signed_mc.sv
// Directed bench for lp_filter_signed_mc: three configurations (1 stage/4 ch, 2 stages/3 ch,
// 0 stages/4 ch) share one stimulus stream and are checked every cycle against a cycle model.
module tb_lp_filter_signed_mc;

    localparam int NDUT = 3;

    logic                clk = 1'b0;
    logic                RESET_N;
    logic                CE;
    logic                CLEAR;
    logic                IN_VALID;
    logic [1:0]          IN_CHANNEL;
    logic signed [29:0]  IN_VALUE;
    logic [4:0]          SHIFT;

    logic                o_valid [NDUT];
    logic [1:0]          o_ch    [NDUT];
    logic signed [32:0]  o_val   [NDUT];

    int total = 0;
    int bad   = 0;

    // model state
    longint m_acc    [NDUT][4][2];
    logic   m_pv     [NDUT][3];
    int     m_pc     [NDUT][3];
    longint m_px     [NDUT][3];
    logic   m_ov     [NDUT];
    int     m_oc     [NDUT];
    longint m_ox     [NDUT];
    logic   m_primed [NDUT][4];

    always #5 clk = ~clk;

    lp_filter_signed_mc #(.STAGE_COUNT(1), .CHANNEL_COUNT(4)) u_dut_a (
        .CLK(clk), .RESET_N(RESET_N), .CE(CE), .CLEAR(CLEAR), .IN_VALID(IN_VALID),
        .IN_CHANNEL(IN_CHANNEL), .IN_VALUE(IN_VALUE), .SHIFT(SHIFT),
        .OUT_VALID(o_valid[0]), .OUT_CHANNEL(o_ch[0]), .OUT_VALUE(o_val[0])
    );

    lp_filter_signed_mc #(.STAGE_COUNT(2), .CHANNEL_COUNT(3)) u_dut_b (
        .CLK(clk), .RESET_N(RESET_N), .CE(CE), .CLEAR(CLEAR), .IN_VALID(IN_VALID),
        .IN_CHANNEL(IN_CHANNEL), .IN_VALUE(IN_VALUE), .SHIFT(SHIFT),
        .OUT_VALID(o_valid[1]), .OUT_CHANNEL(o_ch[1]), .OUT_VALUE(o_val[1])
    );

    lp_filter_signed_mc #(.STAGE_COUNT(0), .CHANNEL_COUNT(4)) u_dut_c (
        .CLK(clk), .RESET_N(RESET_N), .CE(CE), .CLEAR(CLEAR), .IN_VALID(IN_VALID),
        .IN_CHANNEL(IN_CHANNEL), .IN_VALUE(IN_VALUE), .SHIFT(SHIFT),
        .OUT_VALID(o_valid[2]), .OUT_CHANNEL(o_ch[2]), .OUT_VALUE(o_val[2])
    );

    function automatic int stages_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 0);
    endfunction

    function automatic int chans_of(input int d);
        return (d == 1) ? 3 : 4;
    endfunction

    function automatic longint trunc33(input longint v);
        logic signed [32:0] t;
        t = v[32:0];
        return longint'(t);
    endfunction

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < 4; c++) begin
                m_primed[d][c] = 1'b0;
                for (int k = 0; k < 2; k++) m_acc[d][c][k] = 0;
            end
            for (int i = 0; i < 3; i++) begin
                m_pv[d][i] = 1'b0;
                m_pc[d][i] = 0;
                m_px[d][i] = 0;
            end
            m_ov[d] = 1'b0;
            m_oc[d] = 0;
            m_ox[d] = 0;
        end
    endtask

    // Samples are applied to the model in acceptance order and delayed by the stage count.
    task automatic model_edge();
        int     nl;
        int     c;
        longint v;
        logic   ld;
        if (!RESET_N) return;
        for (int d = 0; d < NDUT; d++) begin
            nl = stages_of(d);
            if (!CE) begin
                m_ov[d] = 1'b0;
            end else if (CLEAR) begin
                for (int cc = 0; cc < 4; cc++) begin
                    m_primed[d][cc] = 1'b0;
                    for (int k = 0; k < 2; k++) m_acc[d][cc][k] = 0;
                end
                for (int i = 0; i < 3; i++) m_pv[d][i] = 1'b0;
                m_ov[d] = 1'b0;
            end else begin
                for (int i = nl; i > 0; i--) begin
                    m_pv[d][i] = m_pv[d][i-1];
                    m_pc[d][i] = m_pc[d][i-1];
                    m_px[d][i] = m_px[d][i-1];
                end
                m_pv[d][0] = 1'b0;
                if (IN_VALID && int'(IN_CHANNEL) < chans_of(d)) begin
                    c  = int'(IN_CHANNEL);
                    v  = longint'(IN_VALUE) * 8;
                    ld = 1'b0;
`ifdef LP_FILTER_SIGNED_MC_PRELOAD_EN
                    ld = !m_primed[d][c];
                    m_primed[d][c] = 1'b1;
`endif
                    for (int k = 0; k < nl; k++) begin
                        if (ld) begin
                            m_acc[d][c][k] = v;
                        end else begin
                            m_acc[d][c][k] = trunc33(m_acc[d][c][k] + ((v - m_acc[d][c][k]) >>> SHIFT));
                            v = m_acc[d][c][k];
                        end
                    end
                    m_pv[d][0] = 1'b1;
                    m_pc[d][0] = c;
                    m_px[d][0] = v;
                end
                m_ov[d] = m_pv[d][nl];
                if (m_ov[d]) begin
                    m_oc[d] = m_pc[d][nl];
                    m_ox[d] = m_px[d][nl];
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_valid", d), o_valid[d], m_ov[d]);
            check($sformatf("d%0d_chan", d), o_ch[d], m_oc[d]);
            check($sformatf("d%0d_value", d), o_val[d], m_ox[d]);
        end
    endtask

    task automatic tick(input logic ce_i, input logic clr_i, input logic vld_i,
                        input int ch_i, input int val_i, input int sh_i);
        @(negedge clk);
        CE         = ce_i;
        CLEAR      = clr_i;
        IN_VALID   = vld_i;
        IN_CHANNEL = 2'(ch_i);
        IN_VALUE   = 30'(val_i);
        SHIFT      = 5'(sh_i);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        logic signed [32:0] prev;
        int                 e;
        model_reset();
        RESET_N    = 1'b0;
        CE         = 1'b0;
        CLEAR      = 1'b0;
        IN_VALID   = 1'b0;
        IN_CHANNEL = '0;
        IN_VALUE   = '0;
        SHIFT      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        check("reset_value_a", o_val[0], 0);
        @(negedge clk);
        RESET_N = 1'b1;

        // positive step on ch0, SHIFT=5
        tick(1'b1, 1'b0, 1'b1, 0, 109377165, 5);
        check("step_first_c", o_val[2], 875017320);
        check("step_lat_a_low", o_valid[0], 0);
        tick(1'b1, 1'b0, 1'b1, 0, 109377165, 5);
        check("step_first_a", o_val[0], 27344291);
        check("step_lat_a", o_valid[0], 1);
        for (int i = 0; i < 750; i++) tick(1'b1, 1'b0, 1'b1, 0, 109377165, 5);
        check("step_conv_a", (o_val[0] <= 875017320) && (o_val[0] >= 875017289), 1);

        // negative step: monotonic approach from above to the exact target
        prev = 33'sd875017320;
        for (int i = 0; i < 950; i++) begin
            tick(1'b1, 1'b0, 1'b1, 0, -218754330, 5);
            check("down_mono_a", o_val[0] <= prev, 1);
            prev = o_val[0];
        end
        idle(3);
        check("down_exact_a", o_val[0], -1750034640);

        // interleaved channels, pass-through stages
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b1, i % 2, (i % 2) ? -1000 : 1000, 0);
            check("ilv_c_chan", o_ch[2], i % 2);
            check("ilv_c_value", o_val[2], (i % 2) ? -8000 : 8000);
            check("ilv_b_valid", o_valid[1], (i >= 2) ? 1 : 0);
            if (i >= 2) begin
                check("ilv_b_chan", o_ch[1], i % 2);
                check("ilv_b_value", o_val[1], (i % 2) ? -8000 : 8000);
            end
        end
        idle(3);

        // clear with a simultaneous sample flushes everything
        tick(1'b1, 1'b0, 1'b1, 0, 1000, 1);
        tick(1'b1, 1'b0, 1'b1, 0, 1000, 1);
        tick(1'b1, 1'b1, 1'b1, 0, 1000, 1);
        for (int i = 0; i < 3; i++) begin
            check("clr_flush_a", o_valid[0], 0);
            check("clr_flush_b", o_valid[1], 0);
            check("clr_flush_c", o_valid[2], 0);
            idle(1);
        end
        tick(1'b1, 1'b0, 1'b1, 0, 1000, 1);
        check("clr_restart_c", o_val[2], 8000);
        idle(1);
        check("clr_restart_a", o_val[0], 4000);
        idle(3);

        // out-of-range channel for the 3-channel build
        tick(1'b1, 1'b1, 1'b0, 0, 0, 0);
        tick(1'b1, 1'b0, 1'b1, 3, 500, 2);
        check("drop_c_chan", o_ch[2], 3);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("drop_b_valid", o_valid[1], 0);
        end

        // first sample on a fresh channel
        tick(1'b1, 1'b1, 1'b0, 0, 0, 0);
        tick(1'b1, 1'b0, 1'b1, 2, 500, 2);
        idle(1);
`ifdef LP_FILTER_SIGNED_MC_PRELOAD_EN
        e = 4000;
`else
        e = 1000;
`endif
        check("first_ch2_a", o_val[0], e);
        idle(1);
`ifdef LP_FILTER_SIGNED_MC_PRELOAD_EN
        e = 4000;
`else
        e = 250;
`endif
        check("first_ch2_b", o_val[1], e);
        idle(3);

        // random CE gaps with an asynchronous reset in the middle
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                @(negedge clk);
                #2;
                RESET_N = 1'b0;
                #1;
                for (int d = 0; d < NDUT; d++) begin
                    check("rst_async_valid", o_valid[d], 0);
                    check("rst_async_chan", o_ch[d], 0);
                    check("rst_async_value", o_val[d], 0);
                end
                model_reset();
                @(posedge clk);
                #1;
                check_all();
                @(negedge clk);
                RESET_N = 1'b1;
            end else begin
                tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 400000000)) - 200000000,
                     int'($urandom_range(0, 6)));
            end
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
